// File: rtl/vga_fetch_scheduler.sv
// vga_fetch_scheduler: paces RP2040 framebuffer fetches into a small prefetch FIFO for the VGA pixel path.
module vga_fetch_scheduler #(
  parameter int DEPTH = 4,
  parameter int STROBE_CYCLES = 1,
  parameter int FETCH_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       frame_start,
  input  logic       pix_req,
  output logic [3:0] pix_data,
  output logic       pix_valid,
  output logic       underflow,
  output logic       frame_next_pixel_out,
  output logic       frame_reset_out,
  input  logic [3:0] frame_pixel_in
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2((STROBE_CYCLES > FETCH_LATENCY ? STROBE_CYCLES : FETCH_LATENCY) + 1);
  localparam logic [TW-1:0] S_LAST = TW'(STROBE_CYCLES - 1);
  localparam logic [TW-1:0] F_LAST = TW'(FETCH_LATENCY - 1);
  typedef enum logic [1:0] {IDLE, FRESET, STROBE, WAIT} state_t;
  state_t state, state_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [3:0] mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [CW-1:0] count;
  logic push, pop;
  assign pix_valid = count != '0;
  assign pix_data = mem[rptr];
  assign pop = pix_req && pix_valid && !frame_start;
  always_comb begin
    state_n = state;
    tmr_n = '0;
    push = 1'b0;
    case (state)
      IDLE: state_n = (enable && count < CW'(DEPTH)) ? STROBE : IDLE;
      FRESET: begin
        state_n = tmr == S_LAST ? IDLE : FRESET;
        tmr_n = tmr == S_LAST ? '0 : tmr + 1'b1;
      end
      STROBE: begin
        state_n = tmr == S_LAST ? WAIT : STROBE;
        tmr_n = tmr == S_LAST ? '0 : tmr + 1'b1;
      end
      WAIT: begin
        push = tmr == F_LAST;
        state_n = push ? IDLE : WAIT;
        tmr_n = push ? '0 : tmr + 1'b1;
      end
    endcase
    // a frame restart drops whatever fetch is in flight
    if (frame_start) begin
      state_n = FRESET;
      tmr_n = '0;
      push = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tmr <= '0;
      rptr <= '0;
      wptr <= '0;
      count <= '0;
      underflow <= 1'b0;
      frame_reset_out <= 1'b0;
      frame_next_pixel_out <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      tmr <= tmr_n;
      frame_reset_out <= state_n == FRESET;
      frame_next_pixel_out <= state_n == STROBE;
      if (push) mem[wptr] <= frame_pixel_in;
      if (frame_start) begin
        rptr <= '0;
        wptr <= '0;
        count <= '0;
        underflow <= 1'b0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
        if (pix_req && !pix_valid) underflow <= 1'b1;
      end
    end
  end
endmodule
